rmw_mem_sequencer: RTL and testbench

//  Front-end controller for the small single-read-port / single-write-port RAM (8 x 32b default).
//  Two requesters share the RAM through round-robin arbitration.

---
 rtl/rmw_mem_sequencer.sv | 149 ++++++++++++++
 tb/tb_rmw_mem_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rmw_mem_sequencer.sv
// Round-robin front end for a 1R/1W RAM; masked writes run as read-modify-write.
// Optional RMW_FULLMASK_BYPASS_EN: full-mask writes skip the read state.
module rmw_mem_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [MASK_W-1:0] req0_mask,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [MASK_W-1:0] req1_mask,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic              write_q;
  logic              id_q;
  logic              bypass_q;
  logic [DATA_W-1:0] old_q;

  logic              gnt0;
  logic              gnt1;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_mask;
  logic              take_bypass;
  logic [DATA_W-1:0] bytemask;

  // Grant only in IDLE and never while reset is being sampled.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_write = gnt1 ? req1_write : req0_write;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign sel_mask  = gnt1 ? req1_mask  : req0_mask;

`ifdef RMW_FULLMASK_BYPASS_EN
  assign take_bypass = sel_write && (&sel_mask);
`else
  assign take_bypass = 1'b0;
`endif

  always_comb begin
    bytemask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      bytemask[8*i +: 8] = {8{mask_q[i]}};
    end
  end

  // With a full mask the merge reduces to wdata_q, so the bypass path shares it.
  assign mem_wdata = (old_q & ~bytemask) | (wdata_q & bytemask);
  assign mem_wen   = (state == WR) && (|mask_q) && !reset;
  assign mem_waddr = addr_q;
  assign mem_raddr = addr_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      write_q    <= 1'b0;
      id_q       <= 1'b0;
      bypass_q   <= 1'b0;
      old_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            mask_q     <= sel_mask;
            write_q    <= sel_write;
            id_q       <= gnt1;
            bypass_q   <= take_bypass;
            last_grant <= gnt1;
            state      <= take_bypass ? WR : RD;
          end
        end
        RD: begin
          old_q <= mem_rdata;
          if (write_q) begin
            state <= WR;
          end else begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_rdata <= mem_rdata;
          end
        end
        WR: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_id    <= id_q;
          resp_rdata <= bypass_q ? mem_rdata : old_q;
          if (bypass_q) old_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmw_mem_sequencer.sv
// Directed bench for rmw_mem_sequencer with a behavioural 8 x 32b RAM.
module tb_rmw_mem_sequencer;

`ifdef RMW_FULLMASK_BYPASS_EN
  localparam int FULL_LAT = 2;
`else
  localparam int FULL_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write;
  logic [2:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_mask;
  logic        req1_valid, req1_ready, req1_write;
  logic [2:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic [3:0]  req1_mask;
  logic        resp_valid, resp_id;
  logic [31:0] resp_rdata;
  logic [2:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        mem_wen, busy;

  logic [31:0] ram [8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rmw_mem_sequencer dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_mask(req0_mask),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_mask(req1_mask),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
  );

  assign mem_rdata = ram[mem_raddr];
  always @(posedge clk) if (mem_wen) ram[mem_waddr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current IDLE cycle and follow it to its response.
  task automatic do_op(input string tag, input logic id, input logic wr, input logic [2:0] addr,
                       input logic [31:0] wd, input logic [3:0] mk, input logic [31:0] exp_rd,
                       input int exp_lat, input int exp_wen_cnt, input logic [31:0] exp_wd);
    int resp_cyc = 0;
    int wen_cnt = 0;
    int wen_cyc = 0;
    logic [31:0] got_wd = '0;
    logic [31:0] got_rd = '0;
    logic got_id = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wd; req1_mask = mk;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wd; req0_mask = mk;
    end
    #1;
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 1; c <= 6 && resp_cyc == 0; c++) begin
      if (mem_wen) begin
        wen_cnt++;
        wen_cyc = c;
        got_wd = mem_wdata;
      end
      if (resp_valid) begin
        resp_cyc = c;
        got_rd = resp_rdata;
        got_id = resp_id;
      end else begin
        tick();
      end
    end
    chk({tag, "_lat"}, resp_cyc, exp_lat);
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_id"}, {31'd0, got_id}, {31'd0, id});
    chk({tag, "_wen_cnt"}, wen_cnt, exp_wen_cnt);
    if (exp_wen_cnt > 0) begin
      chk({tag, "_wdata"}, got_wd, exp_wd);
      chk({tag, "_wen_cyc"}, wen_cyc, exp_lat - 1);
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 8; i++) ram[i] = 32'hC0DE_0000 + i;
    reset = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 3'd3; req0_wdata = '0; req0_mask = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 3'd5; req1_wdata = '0; req1_mask = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_wen", {31'd0, mem_wen}, 32'd0);
      chk("rst_resp", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end

    // Both requesters read continuously: grants alternate starting with req0.
    req1_valid = 1'b1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] kb;
      kb = 2'(k);
      chk("arb_ready", {30'd0, req1_ready, req0_ready}, kb[0] ? 32'd2 : 32'd1);
      tick();
      chk("arb_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("arb_resp", {31'd0, resp_valid}, 32'd1);
      chk("arb_id", {31'd0, resp_id}, {31'd0, kb[0]});
      chk("arb_rdata", resp_rdata, kb[0] ? 32'hC0DE_0005 : 32'hC0DE_0003);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    do_op("wr_full", 1'b0, 1'b1, 3'd3, 32'hAABB_CCDD, 4'hF, 32'hC0DE_0003, FULL_LAT, 1, 32'hAABB_CCDD);
    do_op("rd_back", 1'b0, 1'b0, 3'd3, 32'h0,        4'h0, 32'hAABB_CCDD, 2,        0, 32'h0);
    do_op("wr_b0",   1'b1, 1'b1, 3'd3, 32'h1122_3344, 4'h1, 32'hAABB_CCDD, 3,        1, 32'hAABB_CC44);
    do_op("wr_m0",   1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'h0, 32'hAABB_CC44, 3,        0, 32'h0);
    do_op("wr_m6",   1'b1, 1'b1, 3'd3, 32'h5566_7788, 4'h6, 32'hAABB_CC44, 3,        1, 32'hAA66_7744);
    do_op("wr_m3",   1'b0, 1'b1, 3'd5, 32'h1234_5678, 4'h3, 32'hC0DE_0005, 3,        1, 32'hC0DE_5678);
    do_op("rd_m3",   1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 32'hC0DE_5678, 2,        0, 32'h0);

    // Reset lands while the full-mask write is in WR: nothing written, no response.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 3'd3; req0_wdata = 32'h0; req0_mask = 4'hF;
    tick();
    req0_valid = 1'b0;
    if (FULL_LAT == 3) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_wen_pre", {31'd0, mem_wen}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_wen_rst", {31'd0, mem_wen}, 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    chk("mid_no_resp", seen, 0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    do_op("rd_after_rst", 1'b0, 1'b0, 3'd3, 32'h0, 4'h0, 32'hAA66_7744, 2, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
